// File: rtl/tdm_demux8x16.sv
// tdm_demux8x16: round-robin demultiplexer of a 16-bit word stream into
// eight parallel channel slots (a..h), with a capture bank double-buffered
// against the output bank.
// Optional feature macro: TDM_DEMUX_SOF_EN (in_sof restarts the frame).
module tdm_demux8x16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_sof,
    output logic [2:0]  chan,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic [15:0] c,
    output logic [15:0] d,
    output logic [15:0] e,
    output logic [15:0] f,
    output logic [15:0] g,
    output logic [15:0] h,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned W     = 16;
    localparam int unsigned NCH   = 8;
    localparam int unsigned CHW   = 3;

    // cap_q[0..6] collect the partial frame; cap_q[7] parks the last word
    // of a frame that completed while the output bank was still occupied.
    logic [W-1:0]   cap_q  [NCH];
    logic [W-1:0]   cap_n  [NCH];
    logic [W-1:0]   bank_q [NCH];
    logic [W-1:0]   bank_n [NCH];
    logic [CHW-1:0] chan_n;
    logic           pending_q;
    logic           pending_n;
    logic           in_ready_n;
    logic           out_valid_n;
    logic           accept;
    logic           bank_free;
    logic           sof_hit;

`ifdef TDM_DEMUX_SOF_EN
    assign sof_hit = in_sof;
`else
    logic unused_sof;
    assign unused_sof = in_sof;
    assign sof_hit    = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign bank_free = !out_valid || out_ready;

    // Next-state: capture, frame completion, stall parking and draining.
    always_comb begin
        chan_n      = chan;
        cap_n       = cap_q;
        bank_n      = bank_q;
        pending_n   = pending_q;
        out_valid_n = out_valid;

        if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end

        if (pending_q) begin
            // Parked frame moves out as soon as the consumer takes the old one.
            if (out_ready) begin
                bank_n      = cap_q;
                out_valid_n = 1'b1;
                pending_n   = 1'b0;
            end
        end else if (accept) begin
            if (sof_hit) begin
                cap_n[0] = in_data;
                chan_n   = CHW'(1);
            end else if (chan != CHW'(NCH - 1)) begin
                cap_n[chan] = in_data;
                chan_n      = chan + CHW'(1);
            end else begin
                chan_n = '0;
                if (bank_free) begin
                    for (int i = 0; i < NCH - 1; i++) begin
                        bank_n[i] = cap_q[i];
                    end
                    bank_n[NCH-1] = in_data;
                    out_valid_n   = 1'b1;
                end else begin
                    cap_n[NCH-1] = in_data;
                    pending_n    = 1'b1;
                end
            end
        end

        in_ready_n = !pending_n;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            chan      <= '0;
            pending_q <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cap_q[i]  <= '0;
                bank_q[i] <= '0;
            end
        end else begin
            chan      <= chan_n;
            pending_q <= pending_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            cap_q     <= cap_n;
            bank_q    <= bank_n;
        end
    end

    assign a = bank_q[0];
    assign b = bank_q[1];
    assign c = bank_q[2];
    assign d = bank_q[3];
    assign e = bank_q[4];
    assign f = bank_q[5];
    assign g = bank_q[6];
    assign h = bank_q[7];

endmodule

// File: tb/tb_tdm_demux8x16.sv
// Directed self-checking bench for tdm_demux8x16.
module tb_tdm_demux8x16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sof;
    logic [2:0]  chan;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    tdm_demux8x16 dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .chan(chan),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] outw(input int i);
        case (i)
            0: outw = a;
            1: outw = b;
            2: outw = c;
            3: outw = d;
            4: outw = e;
            5: outw = f;
            6: outw = g;
            default: outw = h;
        endcase
    endfunction

    // Present one word for one clock edge; inputs change #1 after the edge.
    task automatic send(input logic [15:0] dw, input logic s);
        in_valid = 1'b1;
        in_data  = dw;
        in_sof   = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outw(i) !== 16'h0000) begin
                errors++;
                $display("FAIL reset_word%0d got=%h exp=0000", i, outw(i));
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (chan !== 3'd0) begin errors++; $display("FAIL reset_chan got=%0d exp=0", chan); end
    endtask

    task automatic test_single_frame;
        logic [15:0] w [8];
        w[0] = 16'h5555; w[1] = 16'hAAAA; w[2] = 16'h00FF; w[3] = 16'hFF00;
        w[4] = 16'h3333; w[5] = 16'hCCCC; w[6] = 16'h0F0F; w[7] = 16'hF0F0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (chan !== 3'(i)) begin errors++; $display("FAIL single_chan%0d got=%0d exp=%0d", i, chan, i); end
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid%0d got=%b exp=0", i, out_valid); end
            send(w[i], 1'b0);
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outw(i) !== w[i]) begin errors++; $display("FAIL single_word%0d got=%h exp=%h", i, outw(i), w[i]); end
        end
        checks++;
        if (chan !== 3'd0) begin errors++; $display("FAIL single_chan_wrap got=%0d exp=0", chan); end
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_consume got=%b exp=0", out_valid); end
        checks++;
        if (h !== 16'hF0F0) begin errors++; $display("FAIL single_hold_h got=%h exp=F0F0", h); end
        out_ready = 1'b0;
    endtask

    task automatic test_stall;
        logic [15:0] f1 [8];
        for (int i = 0; i < 8; i++) f1[i] = 16'h0101 * 16'(i + 1);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(f1[i], 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_f1_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_f2_%0d got=%b exp=1", i, in_ready); end
            send(~f1[i], 1'b0);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid got=%b exp=1", out_valid); end
        checks++;
        if (chan !== 3'd0) begin errors++; $display("FAIL stall_chan got=%0d exp=0", chan); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outw(i) !== f1[i]) begin errors++; $display("FAIL stall_hold%0d got=%h exp=%h", i, outw(i), f1[i]); end
        end
        // Offered words must be refused while the frame is parked.
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        idle(3);
        in_valid = 1'b0;
        checks++;
        if (chan !== 3'd0) begin errors++; $display("FAIL stall_no_accept_chan got=%0d exp=0", chan); end
        checks++;
        if (a !== f1[0]) begin errors++; $display("FAIL stall_no_accept_a got=%h exp=%h", a, f1[0]); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_still_blocked got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outw(i) !== ~f1[i]) begin errors++; $display("FAIL stall_f2_word%0d got=%h exp=%h", i, outw(i), ~f1[i]); end
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_f2_valid got=%b exp=1", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_recover_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_frame;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(16'hBEE0 + 16'(i), 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        checks++;
        if (chan !== 3'd0) begin errors++; $display("FAIL midreset_chan got=%0d exp=0", chan); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 8; i++) send(16'(i + 1), 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset_frame_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outw(i) !== 16'(i + 1)) begin errors++; $display("FAIL midreset_word%0d got=%h exp=%h", i, outw(i), 16'(i + 1)); end
        end
        idle(1);
        out_ready = 1'b0;
    endtask

`ifdef TDM_DEMUX_SOF_EN
    task automatic test_sof_resync;
        logic [15:0] exp [8];
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(16'h0A01 + 16'(i), 1'b0);
        checks++;
        if (chan !== 3'd3) begin errors++; $display("FAIL sof_pre_chan got=%0d exp=3", chan); end
        send(16'h1234, 1'b1);
        checks++;
        if (chan !== 3'd1) begin errors++; $display("FAIL sof_chan got=%0d exp=1", chan); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL sof_no_output got=%b exp=0", out_valid); end
        for (int i = 0; i < 7; i++) send(16'h2001 + 16'(i), 1'b0);
        exp[0] = 16'h1234;
        for (int i = 1; i < 8; i++) exp[i] = 16'h2000 + 16'(i);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL sof_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outw(i) !== exp[i]) begin errors++; $display("FAIL sof_word%0d got=%h exp=%h", i, outw(i), exp[i]); end
        end
        checks++;
        if (chan !== 3'd0) begin errors++; $display("FAIL sof_chan_end got=%0d exp=0", chan); end
        idle(1);
        out_ready = 1'b0;
    endtask
`else
    task automatic test_sof_ignored;
        logic [15:0] exp [8];
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(16'h0A01 + 16'(i), 1'b0);
        send(16'h1234, 1'b1);
        checks++;
        if (chan !== 3'd4) begin errors++; $display("FAIL sofign_chan got=%0d exp=4", chan); end
        for (int i = 0; i < 4; i++) send(16'h2001 + 16'(i), 1'b0);
        exp[0] = 16'h0A01; exp[1] = 16'h0A02; exp[2] = 16'h0A03; exp[3] = 16'h1234;
        exp[4] = 16'h2001; exp[5] = 16'h2002; exp[6] = 16'h2003; exp[7] = 16'h2004;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL sofign_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outw(i) !== exp[i]) begin errors++; $display("FAIL sofign_word%0d got=%h exp=%h", i, outw(i), exp[i]); end
        end
        idle(1);
        out_ready = 1'b0;
    endtask
`endif

    // Consumer takes each frame exactly on the edge the next one completes.
    task automatic test_back_to_back;
        logic [15:0] wd;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_f%0d_w%0d got=%b exp=1", k, i, in_ready); end
                out_ready = (k > 0 && i == 7);
                wd = 16'h4000 | 16'(k << 4) | 16'(i);
                send(wd, 1'b0);
                out_ready = 1'b0;
                if (k > 0 && i == 3) begin
                    wd = 16'h4000 | 16'((k - 1) << 4);
                    checks++;
                    if (a !== wd) begin errors++; $display("FAIL b2b_hold_f%0d got=%h exp=%h", k, a, wd); end
                    checks++;
                    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold_valid_f%0d got=%b exp=1", k, out_valid); end
                end
            end
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_f%0d got=%b exp=1", k, out_valid); end
            for (int i = 0; i < 8; i++) begin
                wd = 16'h4000 | 16'(k << 4) | 16'(i);
                checks++;
                if (outw(i) !== wd) begin errors++; $display("FAIL b2b_f%0d_word%0d got=%h exp=%h", k, i, outw(i), wd); end
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_pending got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        test_reset;
        test_single_frame;
        test_stall;
        test_reset_mid_frame;
`ifdef TDM_DEMUX_SOF_EN
        test_sof_resync;
`else
        test_sof_ignored;
`endif
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
